// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing NUM_REGS registers; frames are R/W, address, data, MSB first.
// Define SPI_READBACK_EN to build the CIPO read-back path; otherwise cipo/cipo_oe are tied low.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | waiting for a fresh synced nCS falling edge
//  CMD   | shifting in the R/W bit and the address
//  DATA  | shifting in data; read frames shift register contents out
//  DONE  | frame complete; commit once, then ignore SCLK until nCS rises
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err,
    output logic                         addr_err
);

    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int SR_W      = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;

    localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   NREG_L    = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ncs_sync, copi_sync;
    logic                   sync_valid, ncs_armed;
    logic                   sclk_rise, ncs_rise, ncs_fall, copi_bit;

    logic [CNT_W-1:0]       bit_cnt;
    logic [SR_W-1:0]        shift_q, shift_nxt;
    logic                   rw_q, done_pend, addr_ok;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];

    // Index 0 samples the pin; the two oldest stages feed the edge detectors.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ncs_sync  <= '1;
            copi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
    assign ncs_rise  = ncs_sync[SYNC_STAGES-2] & ~ncs_sync[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_sync[SYNC_STAGES-2] & ncs_sync[SYNC_STAGES-1];
    assign copi_bit  = copi_sync[SYNC_STAGES-1];

    // The ncs chain resets high, so a pin held low through reset would look like
    // a falling edge; only accept falls after a real high has been sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_valid <= 1'b0;
            ncs_armed  <= 1'b0;
        end else begin
            sync_valid <= 1'b1;
            ncs_armed  <= ncs_armed | (sync_valid & ncs_sync[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ncs_fall && ncs_armed) state_d = CMD;
            CMD: begin
                if (ncs_rise)                                state_d = IDLE;
                else if (sclk_rise && bit_cnt == CMD_LAST)   state_d = DATA;
            end
            DATA: begin
                if (ncs_rise)                                state_d = IDLE;
                else if (sclk_rise && bit_cnt == DATA_LAST)  state_d = DONE;
            end
            DONE: if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign shift_nxt = {shift_q[SR_W-2:0], copi_bit};
    assign addr_ok   = {1'b0, addr_q} < NREG_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            done_pend <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == CMD) begin
                        bit_cnt   <= '0;
                        shift_q   <= '0;
                        done_pend <= 1'b0;
                    end
                end
                CMD: begin
                    if (ncs_rise) begin
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shift_q <= shift_nxt;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CMD_LAST) begin
                            rw_q   <= shift_nxt[ADDR_W];
                            addr_q <= shift_nxt[ADDR_W-1:0];
                        end
                    end
                end
                DATA: begin
                    if (ncs_rise) begin
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shift_q <= shift_nxt;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == DATA_LAST) done_pend <= 1'b1;
                    end
                end
                DONE: begin
                    // Commit exactly once, even if nCS rises in this same cycle.
                    if (done_pend) begin
                        done_pend <= 1'b0;
                        if (!addr_ok) begin
                            addr_err <= 1'b1;
                        end else if (rw_q) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr_q;
                            for (int k = 0; k < NUM_REGS; k++)
                                if (addr_q == ADDR_W'(k)) regs_q[k] <= shift_q[DATA_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W + 1);

    logic              sclk_fall, rd_addr_ok;
    logic [DATA_W-1:0] tx_q, rd_data;

    assign sclk_fall  = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
    assign rd_addr_ok = {1'b0, shift_nxt[ADDR_W-1:0]} < NREG_L;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (shift_nxt[ADDR_W-1:0] == ADDR_W'(k)) rd_data = regs_q[k];
    end

    // The shifter is loaded with the MSB already in place, so the first falling
    // edge of the data phase (count still at DATA_FIRST) must not shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
        end else if (state_q == CMD && !ncs_rise && sclk_rise && bit_cnt == CMD_LAST) begin
            tx_q <= (!shift_nxt[ADDR_W] && rd_addr_ok) ? rd_data : '0;
        end else if (state_q == DATA && sclk_fall && bit_cnt != DATA_FIRST) begin
            tx_q <= tx_q << 1;
        end
    end

    assign cipo_oe = ((state_q == DATA) || (state_q == DONE)) && !rw_q;
    assign cipo    = cipo_oe & tx_q[DATA_W-1];
`else
    assign cipo_oe = 1'b0;
    assign cipo    = 1'b0;
`endif

endmodule
